led_raster: RTL

Parametrised multi-channel serial LED raster engine for the eyes cube display. It takes one pixel word per channel per transfer through a request/valid handshake, double-buffers it, and drives NUM_CHANNELS single-wire pulse-width-coded outputs in lockstep. Each frame ends with a low latch gap. It replaces the fixed seven-shifter raster and its fixed-timing control: the channel count, pixel width, string length and bit timing are all generics.

---
 rtl/led_raster.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/led_raster.sv
// led_raster: double-buffered multi-channel pulse-width LED serialiser, all channels in lockstep, latch gap per frame.
// LED_RASTER_UNDERRUN_EN adds the sticky underrun port and aborts a starved frame to LATCH; otherwise a starved pixel is zero-filled.
module led_raster #(
  parameter int NUM_CHANNELS     = 7,
  parameter int BITS_PER_LED     = 24,
  parameter int LEDS_PER_CHANNEL = 64,
  parameter int TBIT             = 60,
  parameter int T0H              = 17,
  parameter int T1H              = 34,
  parameter int RESET_CYCLES     = 2400
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [NUM_CHANNELS*BITS_PER_LED-1:0] din,
  input  logic                                 din_valid,
  output logic                                 drq,
  output logic                                 finished,
  output logic                                 busy,
  output logic [NUM_CHANNELS-1:0]              sout
`ifdef LED_RASTER_UNDERRUN_EN
  , output logic                               underrun
`endif
);

  localparam int W  = NUM_CHANNELS * BITS_PER_LED;
  localparam int BPL = BITS_PER_LED;
  localparam int PW = $clog2(TBIT);
  localparam int BW = $clog2(BITS_PER_LED);
  localparam int NW = $clog2(LEDS_PER_CHANNEL + 1);
  localparam int LW = $clog2(RESET_CYCLES + 1);

  localparam logic [PW-1:0] PH_LAST    = PW'(TBIT - 1);
  localparam logic [PW-1:0] PH_ONE     = PW'(1);
  localparam logic [PW-1:0] PH_T0H     = PW'(T0H);
  localparam logic [PW-1:0] PH_T1H     = PW'(T1H);
  localparam logic [BW-1:0] BIT_LAST   = BW'(BITS_PER_LED - 1);
  localparam logic [BW-1:0] BIT_ONE    = BW'(1);
  localparam logic [NW-1:0] NPIX       = NW'(LEDS_PER_CHANNEL);
  localparam logic [NW-1:0] PIX_ONE    = NW'(1);
  localparam logic [LW-1:0] LATCH_LAST = LW'(RESET_CYCLES - 1);
  localparam logic [LW-1:0] LAT_ONE    = LW'(1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, DONE} state_t;

  state_t                  r_state;
  logic [W-1:0]            r_hold;
  logic [W-1:0]            r_shift;
  logic                    r_hold_full;
  logic [PW-1:0]           r_phase;
  logic [BW-1:0]           r_bit;
  logic [NW-1:0]           r_accepted;
  logic [NW-1:0]           r_sent;
  logic [LW-1:0]           r_latch;
  logic [NUM_CHANNELS-1:0] r_sout;
  logic                    r_finished;

  logic [W-1:0]            w_shl;
  logic [NUM_CHANNELS-1:0] w_cur_msb;
  logic [NUM_CHANNELS-1:0] w_next_msb;
  logic [NUM_CHANNELS-1:0] w_hold_msb;
  logic                    w_drq;
  logic                    w_accept;

  // The shift register always presents the bit being sent at each channel's MSB.
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    assign w_shl[c*BPL +: BPL] = {r_shift[c*BPL +: BPL-1], 1'b0};
    assign w_cur_msb[c]        = r_shift[c*BPL + BPL-1];
    assign w_next_msb[c]       = r_shift[c*BPL + BPL-2];
    assign w_hold_msb[c]       = r_hold[c*BPL + BPL-1];
  end

  function automatic logic [NUM_CHANNELS-1:0] f_sout(input logic [NUM_CHANNELS-1:0] bits,
                                                     input logic [PW-1:0] ph);
    logic [NUM_CHANNELS-1:0] v;
    for (int c = 0; c < NUM_CHANNELS; c++) v[c] = bits[c] ? (ph < PH_T1H) : (ph < PH_T0H);
    return v;
  endfunction

`ifdef LED_RASTER_UNDERRUN_EN
  logic r_underrun;
  assign underrun = r_underrun;
`endif

  assign w_drq = (r_state != IDLE) && !r_hold_full && (r_accepted < NPIX)
`ifdef LED_RASTER_UNDERRUN_EN
                 && !r_underrun
`endif
                 ;
  assign w_accept = w_drq && din_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_shift     <= '0;
      r_hold_full <= 1'b0;
      r_phase     <= '0;
      r_bit       <= '0;
      r_accepted  <= '0;
      r_sent      <= '0;
      r_latch     <= '0;
      r_sout      <= '0;
      r_finished  <= 1'b0;
`ifdef LED_RASTER_UNDERRUN_EN
      r_underrun  <= 1'b0;
`endif
    end else begin
      r_finished <= 1'b0;
      if (w_accept) begin
        r_hold      <= din;
        r_hold_full <= 1'b1;
        r_accepted  <= r_accepted + PIX_ONE;
      end
      case (r_state)
        IDLE: if (start) begin
          r_state     <= LOAD;
          r_hold_full <= 1'b0;
          r_accepted  <= '0;
          r_sent      <= '0;
          r_phase     <= '0;
          r_bit       <= '0;
          r_latch     <= '0;
          r_sout      <= '0;
`ifdef LED_RASTER_UNDERRUN_EN
          r_underrun  <= 1'b0;
`endif
        end
        LOAD: if (r_hold_full) begin
          r_state     <= SHIFT;
          r_shift     <= r_hold;
          r_hold_full <= 1'b0;
          r_sent      <= PIX_ONE;
          r_phase     <= '0;
          r_bit       <= '0;
          r_sout      <= f_sout(w_hold_msb, '0);
        end
        SHIFT: begin
          if (r_phase != PH_LAST) begin
            r_phase <= r_phase + PH_ONE;
            r_sout  <= f_sout(w_cur_msb, r_phase + PH_ONE);
          end else if (r_bit != BIT_LAST) begin
            r_phase <= '0;
            r_bit   <= r_bit + BIT_ONE;
            r_shift <= w_shl;
            r_sout  <= f_sout(w_next_msb, '0);
          end else if (r_sent == NPIX) begin
            r_state <= LATCH;
            r_latch <= '0;
            r_sout  <= '0;
          end else if (r_hold_full) begin
            r_shift     <= r_hold;
            r_hold_full <= 1'b0;
            r_sent      <= r_sent + PIX_ONE;
            r_phase     <= '0;
            r_bit       <= '0;
            r_sout      <= f_sout(w_hold_msb, '0);
          end else begin
`ifdef LED_RASTER_UNDERRUN_EN
            r_underrun <= 1'b1;
            r_state    <= LATCH;
            r_latch    <= '0;
            r_sout     <= '0;
`else
            // Starved pixel goes out as zero bits so the frame length never changes.
            r_shift <= '0;
            r_sent  <= r_sent + PIX_ONE;
            r_phase <= '0;
            r_bit   <= '0;
            r_sout  <= f_sout('0, '0);
`endif
          end
        end
        LATCH: begin
          r_sout <= '0;
          if (r_latch == LATCH_LAST) r_state <= DONE;
          else r_latch <= r_latch + LAT_ONE;
        end
        DONE: begin
          r_finished <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign drq      = w_drq;
  assign busy     = (r_state != IDLE);
  assign finished = r_finished;
  assign sout     = r_sout;

endmodule
